qracc_bitserial_seq: RTL

QRACC_BITSERIAL_SEQ -- requirements
Module: qracc_bitserial_seq

---
 rtl/qracc_pkg.sv | 16 +
 rtl/qracc_shift_acc.sv | 32 +++
 rtl/qracc_bitserial_seq.sv | 130 +++++++++++++
 3 files changed

// File: rtl/qracc_pkg.sv
// Shared types and helpers for the bit-serial QR accelerator sequencer.
package qracc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DONE    = 2'd3
    } qracc_seq_state_t;

    // Counter width able to hold 0..v-1, never narrower than one bit.
    function automatic int cnt_w(input int v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/qracc_shift_acc.sv
// Per-column shift-accumulate: acc = (acc << 1) + sext(adc) on each enabled cycle.
module qracc_shift_acc #(
    parameter int numCols    = 32,
    parameter int numAdcBits = 4,
    parameter int accBits    = 13
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          en,
    input  logic [numCols*numAdcBits-1:0] adc_in,
    output logic [numCols*accBits-1:0]    acc_out
);

    for (genvar c = 0; c < numCols; c++) begin : g_col
        logic [numAdcBits-1:0] code;
        logic [accBits-1:0]    acc_q;

        assign code = adc_in[c*numAdcBits +: numAdcBits];

        always_ff @(posedge clk) begin
            if (rst || clr)
                acc_q <= '0;
            else if (en)
                acc_q <= {acc_q[accBits-2:0], 1'b0}
                       + {{(accBits-numAdcBits){code[numAdcBits-1]}}, code};
        end

        assign acc_out[c*accBits +: accBits] = acc_q;
    end

endmodule

// File: rtl/qracc_bitserial_seq.sv
// Bit-serial input sequencer: drives one two's-complement bit-plane per step
// (MSB on the negative rail) and shift-accumulates the column ADC codes.
module qracc_bitserial_seq
    import qracc_pkg::*;
#(
    parameter int numRows      = 128,
    parameter int numCols      = 32,
    parameter int numAdcBits   = 4,
    parameter int maxInBits    = 8,
    parameter int accBits      = numAdcBits + maxInBits + 1,
    parameter int adcLatency   = 1,
    parameter int settleCycles = 0,
    parameter int numCfgBits   = $clog2(maxInBits + 1) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [numCfgBits-1:0]         cfg_n_input_bits_i,
    input  logic                          x_valid_i,
    output logic                          x_ready_o,
    input  logic [numRows*maxInBits-1:0]  x_data_i,
    output logic                          mac_en_o,
    output logic [numRows-1:0]            data_p_o,
    output logic [numRows-1:0]            data_n_o,
    input  logic [numCols*numAdcBits-1:0] adc_out_i,
    output logic                          acc_valid_o,
    input  logic                          acc_ready_i,
    output logic [numCols*accBits-1:0]    acc_data_o,
    output logic                          busy_o
);

    if (accBits < numAdcBits + maxInBits) begin : g_bad_acc
        $error("qracc_bitserial_seq: accBits must be >= numAdcBits + maxInBits");
    end

    localparam int PW = cnt_w(maxInBits);
    localparam int LW = cnt_w(adcLatency);
    localparam int SW = cnt_w(settleCycles);

    localparam logic [LW-1:0]         LAT_LAST = LW'(adcLatency - 1);
    localparam logic [SW-1:0]         SET_LAST = SW'(settleCycles - 1);
    localparam logic [numCfgBits-1:0] CFG_MAX  = numCfgBits'(maxInBits);

    qracc_seq_state_t state;
    logic [numRows-1:0][maxInBits-1:0] x_q;
    logic [PW-1:0] msb_q, plane, msb_in;
    logic [LW-1:0] lat_cnt;
    logic [SW-1:0] set_cnt;
    logic          accept, acc_en;

    assign accept = (state == ST_IDLE) && x_valid_i;
    assign acc_en = (state == ST_COMPUTE) && (lat_cnt == LAT_LAST);

    // Precision is clamped to [2, maxInBits]; only n-1 (the MSB plane) is kept.
    always_comb begin
        msb_in = 1'b1;
        if (cfg_n_input_bits_i < 2)
            msb_in = 1'b1;
        else if (cfg_n_input_bits_i > CFG_MAX)
            msb_in = PW'(maxInBits - 1);
        else
            msb_in = PW'(cfg_n_input_bits_i - 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            x_q     <= '0;
            msb_q   <= '0;
            plane   <= '0;
            lat_cnt <= '0;
            set_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: if (x_valid_i) begin
                    x_q     <= x_data_i;
                    msb_q   <= msb_in;
                    plane   <= msb_in;
                    lat_cnt <= '0;
                    set_cnt <= '0;
                    state   <= (settleCycles > 0) ? ST_SETTLE : ST_COMPUTE;
                end
                ST_SETTLE: begin
                    set_cnt <= set_cnt + 1'b1;
                    if (set_cnt == SET_LAST) state <= ST_COMPUTE;
                end
                ST_COMPUTE: begin
                    if (lat_cnt == LAT_LAST) begin
                        lat_cnt <= '0;
                        if (plane == '0) state <= ST_DONE;
                        else             plane <= plane - 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                ST_DONE: if (acc_ready_i) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        data_p_o = '0;
        data_n_o = '0;
        if (state == ST_COMPUTE) begin
            for (int r = 0; r < numRows; r++) begin
                if (plane == msb_q) data_n_o[r] = x_q[r][plane];
                else                data_p_o[r] = x_q[r][plane];
            end
        end
    end

    assign x_ready_o   = (state == ST_IDLE);
    assign mac_en_o    = (state == ST_SETTLE) || (state == ST_COMPUTE);
    assign acc_valid_o = (state == ST_DONE);
    assign busy_o      = (state != ST_IDLE);

    qracc_shift_acc #(
        .numCols    (numCols),
        .numAdcBits (numAdcBits),
        .accBits    (accBits)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (acc_en),
        .adc_in  (adc_out_i),
        .acc_out (acc_data_o)
    );

endmodule
